// File: rtl/filtered_synchronizer.sv
// Multi-channel synchronizer with per-channel glitch filter and optional edge pulses.
// Edge outputs are built only when FILTERED_SYNC_EDGE_EN is defined.
module filtered_synchronizer #(
    parameter int unsigned      WIDTH         = 1,
    parameter int unsigned      STAGES        = 3,
    parameter int unsigned      FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int unsigned    CW      = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    if (WIDTH < 1 || STAGES < 2 || FILTER_CYCLES < 1) begin : g_param_check
        $error("filtered_synchronizer: need WIDTH>=1, STAGES>=2, FILTER_CYCLES>=1");
    end

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] upd;

    // upd marks channels whose mismatch has persisted long enough to propagate this edge
    always_comb begin
        sync = sync_q[STAGES-1];
        upd  = '0;
        for (int unsigned n = 0; n < WIDTH; n++) begin
            upd[n] = (sync[n] != data_o[n]) && (cnt_q[n] == CNT_MAX);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
            for (int unsigned n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
            data_o <= RESET_VAL;
        end else begin
            sync_q[0] <= data_i;
            for (int unsigned k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            data_o <= data_o ^ upd;
            for (int unsigned n = 0; n < WIDTH; n++) begin
                if (sync[n] == data_o[n] || upd[n]) begin
                    cnt_q[n] <= '0;
                end else begin
                    cnt_q[n] <= cnt_q[n] + CW'(1);
                end
            end
        end
    end

`ifdef FILTERED_SYNC_EDGE_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rise_o <= '0;
            fall_o <= '0;
        end else begin
            rise_o <= upd & sync;
            fall_o <= upd & ~sync;
        end
    end
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule

// File: tb/tb_filtered_synchronizer.sv
// Scoreboard bench for filtered_synchronizer (WIDTH=4, STAGES=3, FILTER_CYCLES=4).
// The reference model tracks sampled inputs and propagates a level once FILTER_CYCLES synced samples agree.
module tb_filtered_synchronizer;

    localparam int unsigned W  = 4;
    localparam int unsigned S  = 3;
    localparam int unsigned FC = 4;
    localparam logic [W-1:0] RV = 4'b0000;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [W-1:0] data_i;
    logic [W-1:0] data_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;

    filtered_synchronizer #(
        .WIDTH(W),
        .STAGES(S),
        .FILTER_CYCLES(FC),
        .RESET_VAL(RV)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .data_i(data_i),
        .data_o(data_o),
        .rise_o(rise_o),
        .fall_o(fall_o)
    );

    always #5 clk_i = ~clk_i;

    logic [W-1:0]   hist[$];
    logic [3*W-1:0] exp_q[$];
    logic [W-1:0]   exp_d;
    int             vectors = 0;
    int             miscompares = 0;
    int             cycle = 0;

    task automatic model_reset();
        hist.delete();
        repeat (S + FC) hist.push_back(RV);
        exp_d = RV;
    endtask

    // Drive one cycle of inputs at the falling edge, then advance the model at the rising edge.
    task automatic step(input logic [W-1:0] d, input logic rst_n);
        logic [W-1:0] new_d, r, f;
        bit all1, all0;
        @(negedge clk_i);
        reset_i = rst_n;
        data_i  = d;
        @(posedge clk_i);
        cycle++;
        if (!reset_i) begin
            model_reset();
            exp_q.push_back({RV, {W{1'b0}}, {W{1'b0}}});
        end else begin
            hist.push_back(data_i);
            void'(hist.pop_front());
            new_d = exp_d;
            for (int n = 0; n < int'(W); n++) begin
                all1 = 1'b1;
                all0 = 1'b1;
                for (int k = S; k < int'(S + FC); k++) begin
                    if (hist[hist.size() - 1 - k][n]) all0 = 1'b0;
                    else                              all1 = 1'b0;
                end
                if (all1) new_d[n] = 1'b1;
                if (all0) new_d[n] = 1'b0;
            end
`ifdef FILTERED_SYNC_EDGE_EN
            r = new_d & ~exp_d;
            f = ~new_d & exp_d;
`else
            r = '0;
            f = '0;
`endif
            exp_d = new_d;
            exp_q.push_back({new_d, r, f});
        end
    endtask

    task automatic hold(input logic [W-1:0] d, input int n);
        repeat (n) step(d, 1'b1);
    endtask

    always @(posedge clk_i) begin
        logic [3*W-1:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({data_o, rise_o, fall_o} !== e) begin
                miscompares++;
                $display("FAIL outputs cycle %0d: got data=%h rise=%h fall=%h, expected data=%h rise=%h fall=%h",
                         cycle, data_o, rise_o, fall_o, e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        reset_i = 1'b0;
        data_i  = 4'hF;
        model_reset();

        // Reset with inputs high, then release
        repeat (3) step(4'hF, 1'b0);
        hold(4'hF, 10);
        hold(4'h0, 10);

        // Single-bit step
        hold(4'h1, 10);
        hold(4'h0, 10);

        // Glitch rejection: 3-cycle pulse, then 4-cycle pulse
        hold(4'h2, 3);
        hold(4'h0, 10);
        hold(4'h2, 4);
        hold(4'h0, 12);

        // Independent channels
        hold(4'hC, 2);
        hold(4'h8, 10);
        hold(4'h0, 10);

        // Reset mid-count on bit 0, then full latency after release
        hold(4'h1, 5);
        repeat (2) step(4'h1, 1'b0);
        hold(4'h1, 10);
        hold(4'h0, 10);

        // Alternation at exactly the filter period
        repeat (4) begin
            hold(4'h5, FC);
            hold(4'hA, FC);
        end
        hold(4'h0, 10);

        // Random toggling with occasional reset
        d = '0;
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < int'(W); n++) begin
                if ($urandom_range(3, 0) == 0) d[n] = ~d[n];
            end
            step(d, ($urandom_range(149, 0) != 0));
        end
        hold(d, 10);

        repeat (2) @(posedge clk_i);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/filtered_synchronizer.md
# filtered_synchronizer

Multi-channel asynchronous-input synchronizer with a per-channel glitch filter and optional edge-pulse outputs. Each bit of `data_i` passes through a flop chain of configurable length into `clk_i`, then must hold a new value for `FILTER_CYCLES` consecutive cycles before `data_o` follows. It sits at chip/IP boundaries where slow, level-type control signals (straps, GPIO, interrupt lines, status levels) enter a clock domain and must be both metastability-hardened and debounced. Channels are independent; the block gives no cross-bit coherence guarantee.

## Interface
- `WIDTH`, 1: number of independent channels.
- `STAGES`, 3: synchronizer flop-chain length per channel; must be ≥ 2.
- `FILTER_CYCLES`, 4: consecutive stable cycles required before `data_o` updates; must be ≥ 1.
- `RESET_VAL`, '0 (WIDTH bits): reset value of every chain stage and of `data_o`.

Ports:
- `clk_i`  input  1  destination clock.
- `reset_i`  input  1  reset, asynchronous, active-low.
- `data_i`  input  WIDTH  asynchronous inputs.
- `data_o`  output  WIDTH  synchronized, filtered levels.
- `rise_o`  output  WIDTH  one-cycle pulse when `data_o[n]` goes 0→1.
- `fall_o`  output  WIDTH  one-cycle pulse when `data_o[n]` goes 1→0.

## Operation
- Per channel `n`: chain `s[0..STAGES-1]`; each clock, `s[0] <= data_i[n]` and `s[k] <= s[k-1]`. Define `sync = s[STAGES-1]`.
- Per-channel counter `cnt`, width `$clog2(FILTER_CYCLES+1)`, reset 0.
- Each clock:
  - If `sync == data_o[n]`: `cnt <= 0`.
  - Else if `cnt == FILTER_CYCLES-1`: `data_o[n] <= sync` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- Because the channel is one bit, a mismatch that persists means `sync` holds the same new value. Any return to agreement clears `cnt`, so pulses shorter than `FILTER_CYCLES` (after synchronization) never reach `data_o`.
- `rise_o[n]` and `fall_o[n]` are registered. They are asserted on the same edge that updates `data_o[n]`, for exactly one cycle, and are never both high.
- Channels share no state; simultaneous changes on several bits are filtered independently.
- Elaboration error (`$error`) if `STAGES < 2`, `FILTER_CYCLES < 1`, or `WIDTH < 1`.

## Timing
- Reset (`reset_i` low, asynchronous): all chain stages and `data_o` = `RESET_VAL`; all `cnt` = 0; `rise_o` = `fall_o` = 0. Reset values are chosen so that no edge pulse fires on reset release when `data_i` already equals `RESET_VAL`.
- Latency: a clean step on `data_i[n]`, sampled at edge E, appears on `data_o[n]` at edge E+STAGES+FILTER_CYCLES-1. With defaults that is 6 edges after the sampling edge.
- Minimum propagated pulse width: `FILTER_CYCLES` cycles at the `sync` node. A shorter pulse has no effect on `data_o`.
- Reset asserted mid-count: the count is lost, `data_o` returns to `RESET_VAL`, and any pending pulse is cancelled. After reset release, normal latency applies from the next sampling edge.
- A `data_i` change landing on the same edge where `data_o` updates is simply sampled into `s[0]` and is filtered normally afterwards.
- Back-to-back alternations whose period is at least `FILTER_CYCLES` each propagate; every transition produces exactly one edge pulse.

## Configuration
- `FILTERED_SYNC_EDGE_EN` defined: the `rise_o`/`fall_o` registers are built as described.
- `FILTERED_SYNC_EDGE_EN` undefined: `rise_o` and `fall_o` are tied to 0 and no edge registers are synthesized.
- `data_o` behaviour is identical with and without the macro.

## Test plan
All scenarios use `WIDTH`=4, `STAGES`=3, `FILTER_CYCLES`=4, `RESET_VAL`=4'b0000, macro defined unless noted.
- **Reset values:** hold `reset_i`=0 with `data_i`=4'hF, then release. Required: `data_o`=0 and `rise_o`=`fall_o`=0 throughout reset; after release, `data_o`=4'hF arrives on schedule with `rise_o`=4'hF for exactly 1 cycle.
- **Single-bit step:** `data_i[0]` goes 0→1, sampled at edge E. Required: `data_o[0]`=1 from edge E+6, `rise_o[0]` high only in that cycle, all other bits unchanged.
- **Glitch rejection:** drive a 3-cycle-high pulse on `data_i[1]`. Required: `data_o[1]` stays 0 and `rise_o`/`fall_o` stay 0. Repeat with a 4-cycle pulse. Required: `data_o[1]` high for 4 cycles, one `rise_o[1]` pulse and one `fall_o[1]` pulse.
- **Independent channels:** set bits 2 and 3 high at the same edge, then drop bit 2 two cycles later. Required: `data_o[3]` rises at E+6; `data_o[2]` never rises.
- **Reset mid-count:** assert `reset_i` when `cnt[0]`=2 during a 0→1 transition. Required: `data_o[0]`=0 and no `rise_o` pulse; after release, a full 6-edge latency before `data_o[0]`=1.
- **Macro off:** rerun the single-bit step without `FILTERED_SYNC_EDGE_EN`. Required: `data_o` timing is identical, and `rise_o`=`fall_o`=0 for the whole run.
